// File: rtl/mem_req_queue.sv
// mem_req_queue: in-order request buffer between memory decode and the L1.5 request FSM.
// Stores are posted. Decoded load/store requests wait in a DEPTH-entry FIFO and are offered
// head-first. Once the FSM accepts the head's header, the head is locked and survives a flush.
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   in_*              request from decode (val/addr/data/bw/rd/mem_op/misaligned); in_rdy = not full
//   out_*             head request to the FSM (val/addr/data/bw/rd/mem_op)
//   out_issue         FSM took the head's header; locks the head
//   out_ack           FSM finished the head; pops it
//   flush             drop every entry that is not locked
//   count             occupancy
//   load_pending      at least one load is held, locked or not
module mem_req_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_val,
  input  logic [AW-1:0]              in_addr,
  input  logic [DW-1:0]              in_data,
  input  logic [3:0]                 in_bw,
  input  logic                       in_rd,
  input  logic [3:0]                 in_mem_op,
  input  logic                       in_misaligned,
  output logic                       in_rdy,
  output logic                       out_val,
  output logic [AW-1:0]              out_addr,
  output logic [DW-1:0]              out_data,
  output logic [3:0]                 out_bw,
  output logic                       out_rd,
  output logic [3:0]                 out_mem_op,
  input  logic                       out_issue,
  input  logic                       out_ack,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       load_pending
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [3:0]    bw;
    logic          rd;
    logic [3:0]    mem_op;
  } req_t;

  req_t          mem [DEPTH];
  req_t          head;
  req_t          wr_req;

  logic [PW-1:0] wr_ptr, wr_ptr_n;
  logic [PW-1:0] rd_ptr, rd_ptr_n;
  logic [CW-1:0] count_n;
  logic [CW-1:0] load_cnt, load_cnt_n;
  logic          lock, lock_n;
  logic          push, pop;

  // Head view and handshake decodes
  assign head    = mem[rd_ptr];
  assign out_val = (count != '0);
  assign in_rdy  = (count != CW'(DEPTH));

  // Misaligned and no-op requests are dropped without stalling decode
  assign push = in_val & in_rdy & ~in_misaligned & (in_rd | (|in_bw)) & ~flush;
  assign pop  = out_ack & out_val;

  assign out_addr     = out_val ? head.addr   : '0;
  assign out_data     = out_val ? head.data   : '0;
  assign out_bw       = out_val ? head.bw     : '0;
  assign out_rd       = out_val ? head.rd     : 1'b0;
  assign out_mem_op   = out_val ? head.mem_op : '0;
  assign load_pending = (load_cnt != '0);

  assign wr_req = '{addr: in_addr, data: in_data, bw: in_bw, rd: in_rd, mem_op: in_mem_op};

  // Next-state for pointers, occupancy, load count and head lock
  always_comb begin
    wr_ptr_n   = wr_ptr;
    rd_ptr_n   = rd_ptr;
    count_n    = count;
    load_cnt_n = load_cnt;
    lock_n     = lock;
    if (flush) begin
      if (lock && !out_ack) begin
        // Locked head is already in flight at the L1.5; keep only it
        count_n    = CW'(1);
        wr_ptr_n   = rd_ptr + PW'(1);
        load_cnt_n = CW'(head.rd);
      end else begin
        rd_ptr_n   = rd_ptr + PW'(pop);
        wr_ptr_n   = rd_ptr_n;
        count_n    = '0;
        load_cnt_n = '0;
        lock_n     = 1'b0;
      end
    end else begin
      if (push) wr_ptr_n = wr_ptr + PW'(1);
      if (pop)  rd_ptr_n = rd_ptr + PW'(1);
      count_n    = count + CW'(push) - CW'(pop);
      load_cnt_n = load_cnt + CW'(push & in_rd) - CW'(pop & head.rd);
      // Completion wins over a same-cycle issue: the next head starts unlocked
      if (pop)                              lock_n = 1'b0;
      else if (out_issue && out_val)        lock_n = 1'b1;
    end
  end

  // Control state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      load_cnt <= '0;
      lock     <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_n;
      rd_ptr   <= rd_ptr_n;
      count    <= count_n;
      load_cnt <= load_cnt_n;
      lock     <= lock_n;
    end
  end

  // Payload storage; only entries between rd_ptr and wr_ptr are ever observed
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_req;
  end

endmodule

// File: tb/tb_mem_req_queue.sv
module tb_mem_req_queue;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_val, in_rd, in_misaligned, out_issue, out_ack, flush;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic [3:0]    in_bw, in_mem_op;
  logic          in_rdy, out_val, out_rd, load_pending;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic [3:0]    out_bw, out_mem_op;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  mem_req_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .in_val(in_val), .in_addr(in_addr), .in_data(in_data), .in_bw(in_bw),
    .in_rd(in_rd), .in_mem_op(in_mem_op), .in_misaligned(in_misaligned), .in_rdy(in_rdy),
    .out_val(out_val), .out_addr(out_addr), .out_data(out_data), .out_bw(out_bw),
    .out_rd(out_rd), .out_mem_op(out_mem_op), .out_issue(out_issue), .out_ack(out_ack),
    .flush(flush), .count(count), .load_pending(load_pending)
  );

  // Reference model: a queue of requests plus a "head taken by FSM" flag
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [3:0]    bw;
    logic          rd;
    logic [3:0]    op;
  } ent_t;

  ent_t q[$];
  bit   m_lock;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    bit   v;
    bit   lp;
    ent_t h;
    v  = (q.size() != 0);
    lp = 1'b0;
    foreach (q[i]) if (q[i].rd) lp = 1'b1;
    h = '{addr: '0, data: '0, bw: '0, rd: 1'b0, op: '0};
    if (v) h = q[0];
    check({tag, ".count"},    64'(count),        64'(q.size()));
    check({tag, ".in_rdy"},   64'(in_rdy),       64'(q.size() != DEPTH));
    check({tag, ".out_val"},  64'(out_val),      64'(v));
    check({tag, ".addr"},     64'(out_addr),     64'(h.addr));
    check({tag, ".data"},     64'(out_data),     64'(h.data));
    check({tag, ".bw"},       64'(out_bw),       64'(h.bw));
    check({tag, ".rd"},       64'(out_rd),       64'(h.rd));
    check({tag, ".op"},       64'(out_mem_op),   64'(h.op));
    check({tag, ".ld_pend"},  64'(load_pending), 64'(lp));
  endtask

  // Apply one clock edge to the model using the current input values
  task automatic model_edge();
    bit   valid, full, pop, acc;
    ent_t e;
    valid = (q.size() != 0);
    full  = (q.size() == DEPTH);
    pop   = out_ack && valid;
    acc   = in_val && !full && !in_misaligned && (in_rd || in_bw != 4'b0) && !flush;
    e = '{addr: in_addr, data: in_data, bw: in_bw, rd: in_rd, op: in_mem_op};
    if (flush) begin
      if (m_lock && !out_ack) begin
        while (q.size() > 1) void'(q.pop_back());
      end else begin
        q.delete();
        m_lock = 1'b0;
      end
    end else begin
      if (pop) begin
        void'(q.pop_front());
        m_lock = 1'b0;
      end else if (out_issue && valid) begin
        m_lock = 1'b1;
      end
      if (acc) q.push_back(e);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    in_val = 0; in_addr = '0; in_data = '0; in_bw = '0; in_rd = 0; in_mem_op = '0;
    in_misaligned = 0; out_issue = 0; out_ack = 0; flush = 0;
  endtask

  task automatic set_req(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] bw,
                         input logic rd, input logic [3:0] op);
    in_val = 1; in_addr = a; in_data = d; in_bw = bw; in_rd = rd; in_mem_op = op;
    in_misaligned = 0;
  endtask

  task automatic push_one(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [3:0] bw, input logic rd, input logic [3:0] op);
    set_req(a, d, bw, rd, op);
    step(tag);
    idle();
  endtask

  task automatic do_reset();
    #3 rst = 1'b1;
    #1;
    q.delete();
    m_lock = 1'b0;
    check_all("reset_async");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    m_lock = 1'b0;
    #12;
    check_all("por");
    @(negedge clk);
    rst = 1'b0;

    // 1. reset in the middle of operation
    push_one("t1_p0", 32'h10, 32'hA0, 4'hF, 1'b0, 4'b1100);
    push_one("t1_p1", 32'h14, 32'hA1, 4'hF, 1'b0, 4'b1100);
    push_one("t1_p2", 32'h18, 32'h0,  4'h0, 1'b1, 4'b0100);
    check("t1_pre_count", 64'(count), 64'd3);
    do_reset();
    check("t1_count", 64'(count), 64'd0);
    check("t1_in_rdy", 64'(in_rdy), 64'd1);
    step("t1_after");

    // 2. ordering, latency and load_pending
    push_one("t2_sw", 32'h100, 32'hDEADBEEF, 4'b1111, 1'b0, 4'b1100);
    check("t2_outval_lat", 64'(out_val), 64'd1);
    push_one("t2_sb", 32'h105, 32'h0000AB00, 4'b0010, 1'b0, 4'b1000);
    push_one("t2_lw", 32'h200, 32'h0,        4'b0000, 1'b1, 4'b0100);
    check("t2_ldp", 64'(load_pending), 64'd1);
    for (int i = 0; i < 3; i++) begin
      out_ack = 1;
      step($sformatf("t2_ack%0d", i));
    end
    idle();
    check("t2_ldp_end", 64'(load_pending), 64'd0);

    // 3. full boundary
    for (int i = 0; i < 4; i++)
      push_one($sformatf("t3_p%0d", i), 32'h300 + 32'(4 * i), 32'h1000 + 32'(i), 4'hF, 1'b0, 4'b1100);
    check("t3_full_rdy", 64'(in_rdy), 64'd0);
    push_one("t3_drop", 32'h3F0, 32'h5, 4'hF, 1'b0, 4'b1100);
    set_req(32'h3F4, 32'h6, 4'hF, 1'b0, 4'b1100);
    out_ack = 1;
    step("t3_ack_push");
    check("t3_count3", 64'(count), 64'd3);
    idle();
    out_ack = 1;
    repeat (3) step("t3_drain");
    idle();

    // 4. filtering
    set_req(32'h401, 32'h7, 4'hF, 1'b0, 4'b1100);
    in_misaligned = 1;
    step("t4_mis");
    idle();
    push_one("t4_noop", 32'h404, 32'h8, 4'b0000, 1'b0, 4'b1100);
    check("t4_count", 64'(count), 64'd0);

    // 5. flush with locked head
    push_one("t5_lw", 32'h40, 32'h0,  4'b0000, 1'b1, 4'b0100);
    push_one("t5_s1", 32'h44, 32'h11, 4'b1111, 1'b0, 4'b1100);
    push_one("t5_s2", 32'h48, 32'h22, 4'b1111, 1'b0, 4'b1100);
    out_issue = 1;
    step("t5_issue");
    idle();
    flush = 1;
    step("t5_flush");
    idle();
    check("t5_count", 64'(count), 64'd1);
    check("t5_head", 64'(out_addr), 64'h40);
    check("t5_ldp", 64'(load_pending), 64'd1);
    out_ack = 1;
    step("t5_ack");
    idle();
    check("t5_ldp_end", 64'(load_pending), 64'd0);

    // 6. wrap-around streaming
    push_one("t6_first", 32'h600, 32'hC00, 4'hF, 1'b0, 4'b1100);
    for (int i = 1; i <= 10; i++) begin
      set_req(32'h600 + 32'(4 * i), 32'hC00 + 32'(i), 4'hF, 1'b0, 4'b1100);
      out_ack = 1;
      step($sformatf("t6_s%0d", i));
      check("t6_count1", 64'(count), 64'd1);
    end
    idle();
    out_ack = 1;
    step("t6_last");
    idle();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      in_val        = ($urandom_range(0, 3) != 0);
      in_addr       = $urandom;
      in_data       = $urandom;
      in_rd         = ($urandom_range(0, 2) == 0);
      in_bw         = 4'($urandom);
      in_mem_op     = 4'($urandom);
      in_misaligned = ($urandom_range(0, 9) == 0);
      out_issue     = ($urandom_range(0, 1) == 0);
      out_ack       = ($urandom_range(0, 2) == 0);
      flush         = ($urandom_range(0, 19) == 0);
      step($sformatf("rnd%0d", i));
    end
    idle();
    do_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
